// File: rtl/neopixel_rx.sv
// neopixel_rx: WS2812-style single-wire pixel stream receiver.
// Synchronises data_i, measures high-pulse widths to recover bits, packs 24-bit GRB
// words into a FIFO and flags frame ends, overflow and pulse errors over an OBI port.
// Optional: define NEOPIXEL_RX_GLITCH_FILTER_EN to add a 3-sample majority filter
// behind the synchronizer. It removes 1-cycle glitches and adds 2 cycles to every edge.

package neopixel_rx_pkg;
  typedef struct packed {
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultCfg = '{IdWidth: 32'd1};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    obi_r_chan_t r;
    logic        gnt;
    logic        rvalid;
  } obi_rsp_t;
endpackage

module neopixel_rx #(
  parameter neopixel_rx_pkg::obi_cfg_t ObiCfg = neopixel_rx_pkg::ObiDefaultCfg,
  parameter type obi_req_t = neopixel_rx_pkg::obi_req_t,
  parameter type obi_rsp_t = neopixel_rx_pkg::obi_rsp_t,
  parameter int unsigned FifoDepth   = 8,
  parameter int unsigned BitThresh   = 12,
  parameter int unsigned MaxHigh     = 40,
  parameter int unsigned ResetCycles = 1000
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  input  logic     data_i,
  output logic     irq_o
);

  localparam int unsigned IdW  = ObiCfg.IdWidth;
  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam logic [PtrW:0] DepthLvl  = (PtrW+1)'(FifoDepth);
  localparam logic [15:0]   ThreshCnt = 16'(BitThresh);
  localparam logic [15:0]   MaxCnt    = 16'(MaxHigh);
  localparam logic [15:0]   ResetCnt  = 16'(ResetCycles);

  typedef enum logic [1:0] {S_WAIT_RST, S_IDLE, S_HIGH, S_LOW} state_t;

  // Line path
  logic line_q1, line_s, line_e, line_d_q, rise_q, fall_q;
  logic [15:0] cnt_q;

  // Receiver state
  state_t      state_q;
  logic [23:0] shift_q, shift_next, push_word_q;
  logic [4:0]  bitcnt_q;
  logic        got_word_q, push_q, frame_set_q, err_set_q;

  // Registers and FIFO
  logic ctrl_en_q, ctrl_irq_en_q;
  logic [2:0] sticky_q, sticky_set, sticky_clr;
  logic [23:0] mem_q [FifoDepth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   level_q;
  logic fifo_full, fifo_empty, fifo_wr, pop;

  // OBI
  logic [1:0]  reg_idx;
  logic        req_acc, rd_acc, wr_acc;
  logic [31:0] rdata_d, rdata_q;
  logic        rvalid_q, err_q, irq_q;
  logic [IdW-1:0] rid_q;
  logic        unused_obi;

  // Two-flop synchronizer on the asynchronous pixel line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q1 <= 1'b0;
      line_s  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value; blocking here would collapse the chain.
      line_q1 <= data_i;
      line_s  <= line_q1;
    end
  end

`ifdef NEOPIXEL_RX_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       line_f_q;

  // Majority of the last three synchronized samples; a lone 1-cycle sample never wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q   <= 2'b00;
      line_f_q <= 1'b0;
    end else begin
      hist_q   <= {hist_q[0], line_s};
      line_f_q <= (line_s & hist_q[0]) | (line_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end
  assign line_e = line_f_q;
`else
  assign line_e = line_s;
`endif

  // Registered edge detect; line_d_q is the line level aligned with rise_q/fall_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_d_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      line_d_q <= line_e;
      rise_q   <= line_e & ~line_d_q;
      fall_q   <= ~line_e & line_d_q;
    end
  end

  // Cycles since the last edge, saturating; held at zero while high in WAIT_RST.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (rise_q || fall_q || (state_q == S_WAIT_RST && line_d_q)) begin
      cnt_q <= '0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // At a falling edge cnt_q holds width-1, so a bit is 1 when that reaches the threshold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    shift_next = {shift_q[22:0], (cnt_q >= ThreshCnt)};
  end

  // Bit recovery FSM: waits for a reset gap, then classifies each high pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_WAIT_RST;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      got_word_q  <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      frame_set_q <= 1'b0;
      err_set_q   <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_set_q <= 1'b0;
      err_set_q   <= 1'b0;
      if (!ctrl_en_q) begin
        state_q    <= S_WAIT_RST;
        shift_q    <= '0;
        bitcnt_q   <= '0;
        got_word_q <= 1'b0;
      end else begin
        unique case (state_q)
          S_WAIT_RST: begin
            shift_q    <= '0;
            bitcnt_q   <= '0;
            got_word_q <= 1'b0;
            if (!line_d_q && cnt_q >= ResetCnt) state_q <= S_IDLE;
          end
          S_IDLE, S_LOW: begin
            if (rise_q) begin
              state_q <= S_HIGH;
            end else if (state_q == S_LOW && cnt_q >= ResetCnt) begin
              err_set_q   <= (bitcnt_q != '0);
              frame_set_q <= got_word_q;
              shift_q     <= '0;
              bitcnt_q    <= '0;
              got_word_q  <= 1'b0;
              state_q     <= S_IDLE;
            end
          end
          S_HIGH: begin
            if (cnt_q > MaxCnt) begin
              err_set_q <= 1'b1;
              state_q   <= S_WAIT_RST;
            end else if (fall_q) begin
              shift_q <= shift_next;
              state_q <= S_LOW;
              if (bitcnt_q == 5'd23) begin
                push_q      <= 1'b1;
                push_word_q <= shift_next;
                got_word_q  <= 1'b1;
                bitcnt_q    <= '0;
              end else begin
                bitcnt_q <= bitcnt_q + 1'b1;
              end
            end
          end
          default: state_q <= S_WAIT_RST;
        endcase
      end
    end
  end

  // OBI decode; the address window is 4 words, selected by addr[3:2].
  assign reg_idx    = obi_req_i.a.addr[3:2];
  assign req_acc    = obi_req_i.req;
  assign rd_acc     = req_acc & ~obi_req_i.a.we;
  assign wr_acc     = req_acc & obi_req_i.a.we;
  assign fifo_full  = (level_q == DepthLvl);
  assign fifo_empty = (level_q == '0);
  assign pop        = rd_acc && reg_idx == 2'd0 && !fifo_empty;
  assign fifo_wr    = push_q && (!fifo_full || pop);
  assign sticky_set = {err_set_q, push_q & fifo_full & ~pop, frame_set_q};
  assign sticky_clr = (wr_acc && reg_idx == 2'd2) ? obi_req_i.a.wdata[10:8] : 3'b000;
  assign unused_obi = ^{obi_req_i.a.addr[31:4], obi_req_i.a.addr[1:0], obi_req_i.a.be,
                        obi_req_i.a.wdata[31:11], obi_req_i.a.wdata[7:2]};

  // FIFO storage.
  always_ff @(posedge clk_i) begin
    // NOTE: the word array has no reset; validity is tracked by the reset pointers and level.
    if (fifo_wr) mem_q[wptr_q] <= push_word_q;
  end

  // FIFO pointers and fill level; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (fifo_wr) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      case ({fifo_wr, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // CTRL, sticky status bits (set beats clear) and the registered interrupt.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_en_q     <= 1'b0;
      ctrl_irq_en_q <= 1'b0;
      sticky_q      <= '0;
      irq_q         <= 1'b0;
    end else begin
      if (wr_acc && reg_idx == 2'd1) begin
        ctrl_en_q     <= obi_req_i.a.wdata[0];
        ctrl_irq_en_q <= obi_req_i.a.wdata[1];
      end
      sticky_q <= (sticky_q & ~sticky_clr) | sticky_set;
      irq_q    <= ctrl_irq_en_q & (|sticky_q);
    end
  end

  // Read data mux.
  always_comb begin
    rdata_d = '0;
    unique case (reg_idx)
      2'd0:    rdata_d = fifo_empty ? 32'h0 : {1'b1, 7'b0, mem_q[rptr_q]};
      2'd1:    rdata_d = {30'b0, ctrl_irq_en_q, ctrl_en_q};
      2'd2:    rdata_d = {21'b0, sticky_q, 8'(level_q)};
      default: rdata_d = '0;
    endcase
  end

  // Response phase, one cycle after each granted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= req_acc;
      rid_q    <= req_acc ? obi_req_i.a.aid : '0;
      err_q    <= req_acc && reg_idx == 2'd3;
      rdata_q  <= rd_acc ? rdata_d : '0;
    end
  end

  // Assemble the response struct; gnt is combinational.
  always_comb begin
    obi_rsp_o         = '0;
    obi_rsp_o.gnt     = obi_req_i.req;
    obi_rsp_o.rvalid  = rvalid_q;
    obi_rsp_o.r.rdata = rdata_q;
    obi_rsp_o.r.rid   = rid_q;
    obi_rsp_o.r.err   = err_q;
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_neopixel_rx.sv
// tb_neopixel_rx: directed bench for neopixel_rx driving WS2812-style pulses and
// OBI register accesses, comparing against hand-computed register values.

module tb_neopixel_rx;
  import neopixel_rx_pkg::*;

  localparam logic [31:0] A_DATA   = 32'h0;
  localparam logic [31:0] A_CTRL   = 32'h4;
  localparam logic [31:0] A_STATUS = 32'h8;
  localparam logic [31:0] A_UNMAP  = 32'hC;

  logic     clk_i = 1'b0;
  logic     rst_ni;
  logic     data_i;
  logic     irq_o;
  obi_req_t obi_req;
  obi_rsp_t obi_rsp;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic aid_next = 1'b0;

  logic [23:0] ovf_words [10] = '{24'h123456, 24'hFEDCBA, 24'h000001, 24'h800000, 24'hFFFFFF,
                                  24'h000000, 24'h55AA55, 24'hAA55AA, 24'h0F0F0F, 24'hF0F0F0};

  neopixel_rx dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .obi_req_i (obi_req),
    .obi_rsp_o (obi_rsp),
    .data_i    (data_i),
    .irq_o     (irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Bus access; also checks gnt, rvalid and rid echo for every transfer.
  task automatic obi_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
    logic aid;
    aid = aid_next;
    @(negedge clk_i);
    obi_req.req     = 1'b1;
    obi_req.a.we    = we;
    obi_req.a.addr  = addr;
    obi_req.a.be    = 4'hF;
    obi_req.a.wdata = wdata;
    obi_req.a.aid   = aid;
    #1;
    n_checks++;
    if (obi_rsp.gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL obi_gnt addr %h: got %b expected 1", addr, obi_rsp.gnt);
    end
    @(posedge clk_i);
    #1;
    obi_req.req = 1'b0;
    n_checks++;
    if (obi_rsp.rvalid !== 1'b1 || obi_rsp.r.rid !== aid) begin
      n_fail++;
      $display("FAIL obi_rvalid_rid addr %h: got rvalid=%b rid=%b expected rvalid=1 rid=%b",
               addr, obi_rsp.rvalid, obi_rsp.r.rid, aid);
    end
    rdata    = obi_rsp.r.rdata;
    err      = obi_rsp.r.err;
    aid_next = ~aid_next;
  endtask

  task automatic obi_read(input logic [31:0] addr, output logic [31:0] rdata, output logic err);
    obi_access(1'b0, addr, 32'h0, rdata, err);
  endtask

  task automatic obi_write(input logic [31:0] addr, input logic [31:0] wdata, output logic err);
    logic [31:0] dummy;
    obi_access(1'b1, addr, wdata, dummy, err);
  endtask

  task automatic send_bit(input logic b);
    data_i = 1'b1;
    repeat (b ? 16 : 6) @(negedge clk_i);
    data_i = 1'b0;
    repeat (b ? 9 : 19) @(negedge clk_i);
  endtask

  task automatic send_bits(input logic [23:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(w[23-i]);
  endtask

  task automatic send_gap();
    data_i = 1'b0;
    repeat (1008) @(negedge clk_i);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic er;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    n_checks++;
    if (obi_rsp !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: got %h expected 0", obi_rsp);
    end
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b expected 0", irq_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    obi_read(A_CTRL, rd, er);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %h err=%b expected 00000000 err=0", rd, er);
    end
    obi_read(A_STATUS, rd, er);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_status: got %h expected 00000000", rd);
    end
    obi_read(A_DATA, rd, er);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h err=%b expected 00000000 err=0", rd, er);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] rd;
    logic er;
    obi_write(A_CTRL, 32'h1, er);
    send_gap();
    send_bits(24'hA5C3F0, 24);
    send_gap();
    obi_read(A_STATUS, rd, er);
    n_checks++;
    if (rd !== 32'h0000_0101) begin
      n_fail++;
      $display("FAIL single_status_before: got %h expected 00000101", rd);
    end
    obi_read(A_DATA, rd, er);
    n_checks++;
    if (rd !== 32'h80A5_C3F0) begin
      n_fail++;
      $display("FAIL single_data: got %h expected 80a5c3f0", rd);
    end
    obi_read(A_STATUS, rd, er);
    n_checks++;
    if (rd !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL single_status_after: got %h expected 00000100", rd);
    end
    obi_write(A_STATUS, 32'h700, er);
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    logic er;
    for (int i = 0; i < 10; i++) send_bits(ovf_words[i], 24);
    send_gap();
    obi_read(A_STATUS, rd, er);
    n_checks++;
    if (rd !== 32'h0000_0308) begin
      n_fail++;
      $display("FAIL ovf_status: got %h expected 00000308", rd);
    end
    for (int i = 0; i < 8; i++) begin
      obi_read(A_DATA, rd, er);
      n_checks++;
      if (rd !== {8'h80, ovf_words[i]}) begin
        n_fail++;
        $display("FAIL ovf_data[%0d]: got %h expected %h", i, rd, {8'h80, ovf_words[i]});
      end
    end
    obi_read(A_DATA, rd, er);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL ovf_data_empty: got %h expected 00000000", rd);
    end
    obi_write(A_STATUS, 32'h700, er);
    obi_read(A_STATUS, rd, er);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL ovf_w1c: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_pulse_error();
    logic [31:0] rd;
    logic er;
    data_i = 1'b1;
    repeat (50) @(negedge clk_i);
    data_i = 1'b0;
    repeat (30) @(negedge clk_i);
    obi_read(A_STATUS, rd, er);
    n_checks++;
    if (rd !== 32'h0000_0400) begin
      n_fail++;
      $display("FAIL perr_status: got %h expected 00000400", rd);
    end
    send_bits(24'h123456, 24);
    send_gap();
    obi_read(A_STATUS, rd, er);
    n_checks++;
    if (rd !== 32'h0000_0400) begin
      n_fail++;
      $display("FAIL perr_no_gap_word: got %h expected 00000400", rd);
    end
    send_bits(24'h0F0F0F, 24);
    send_gap();
    obi_read(A_STATUS, rd, er);
    n_checks++;
    if (rd !== 32'h0000_0501) begin
      n_fail++;
      $display("FAIL perr_after_gap_status: got %h expected 00000501", rd);
    end
    obi_read(A_DATA, rd, er);
    n_checks++;
    if (rd !== 32'h800F_0F0F) begin
      n_fail++;
      $display("FAIL perr_after_gap_data: got %h expected 800f0f0f", rd);
    end
    obi_write(A_STATUS, 32'h700, er);
  endtask

  task automatic test_partial_word();
    logic [31:0] rd;
    logic er;
    send_bits(24'hABC000, 12);
    send_gap();
    obi_read(A_STATUS, rd, er);
    n_checks++;
    if (rd !== 32'h0000_0400) begin
      n_fail++;
      $display("FAIL partial_status: got %h expected 00000400", rd);
    end
    obi_write(A_STATUS, 32'h700, er);
    obi_read(A_STATUS, rd, er);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL partial_w1c: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_irq_and_err();
    logic [31:0] rd;
    logic er;
    obi_write(A_CTRL, 32'h3, er);
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_idle: got %b expected 0", irq_o);
    end
    send_bits(24'hC0FFEE, 24);
    send_gap();
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_frame: got %b expected 1", irq_o);
    end
    obi_read(A_DATA, rd, er);
    n_checks++;
    if (rd !== 32'h80C0_FFEE) begin
      n_fail++;
      $display("FAIL irq_data: got %h expected 80c0ffee", rd);
    end
    obi_write(A_STATUS, 32'h100, er);
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_w1c_same_cycle: got %b expected 1", irq_o);
    end
    @(posedge clk_i);
    #1;
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_w1c_next_cycle: got %b expected 0", irq_o);
    end
    obi_read(A_UNMAP, rd, er);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL unmapped_read: got err=%b rdata=%h expected err=1 rdata=00000000", er, rd);
    end
    obi_write(A_UNMAP, 32'hFFFF_FFFF, er);
    n_checks++;
    if (er !== 1'b1) begin
      n_fail++;
      $display("FAIL unmapped_write: got err=%b expected 1", er);
    end
    obi_read(A_DATA, rd, er);
    n_checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL empty_read: got err=%b rdata=%h expected err=0 rdata=00000000", er, rd);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] rd;
    logic er;
    send_bits(24'h5A5A5A, 24);
    send_gap();
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre_irq: got %b expected 1", irq_o);
    end
    fork
      send_bits(24'h3C3C3C, 24);
      begin
        repeat (255) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (obi_rsp !== '0 || irq_o !== 1'b0) begin
          n_fail++;
          $display("FAIL mid_reset_outputs: got rsp=%h irq=%b expected rsp=0 irq=0", obi_rsp, irq_o);
        end
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (20) @(negedge clk_i);
        obi_write(A_CTRL, 32'h1, er);
      end
    join
    send_gap();
    obi_read(A_STATUS, rd, er);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_no_push: got %h expected 00000000", rd);
    end
    obi_read(A_CTRL, rd, er);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++;
      $display("FAIL mid_ctrl: got %h expected 00000001", rd);
    end
    send_bits(24'h3C3C3C, 24);
    send_gap();
    obi_read(A_DATA, rd, er);
    n_checks++;
    if (rd !== 32'h803C_3C3C) begin
      n_fail++;
      $display("FAIL mid_next_word: got %h expected 803c3c3c", rd);
    end
    obi_read(A_STATUS, rd, er);
    n_checks++;
    if (rd !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL mid_status: got %h expected 00000100", rd);
    end
  endtask

  initial begin
    obi_req = '0;
    data_i  = 1'b0;
    rst_ni  = 1'b0;
    test_reset();
    test_single_frame();
    test_overflow();
    test_pulse_error();
    test_partial_word();
    test_irq_and_err();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
